// File: rtl/mc_sequencer_pkg.sv
// Shared definitions for the multi-cycle sequencer: state encodings and
// halt codes used by the sequencer and its watchdog.
package mc_sequencer_pkg;

  // Sequencer states, 3-bit encoding
  typedef enum logic [2:0] {
    SEQ_IDLE     = 3'd0,
    SEQ_IF_REQ   = 3'd1,
    SEQ_IF_WAIT  = 3'd2,
    SEQ_DECODE   = 3'd3,
    SEQ_MEM_REQ  = 3'd4,
    SEQ_MEM_WAIT = 3'd5,
    SEQ_WB       = 3'd6,
    SEQ_HALT     = 3'd7
  } seq_state_t;

  // Reason the core stopped
  typedef enum logic [1:0] {
    HALT_NONE    = 2'b00,
    HALT_EBREAK  = 2'b01,
    HALT_ILLEGAL = 2'b10,
    HALT_TIMEOUT = 2'b11
  } halt_code_t;

  // True for the states in which the core waits on a memory port
  function automatic logic is_mem_phase(input seq_state_t s);
    return (s == SEQ_IF_REQ) || (s == SEQ_IF_WAIT) ||
           (s == SEQ_MEM_REQ) || (s == SEQ_MEM_WAIT);
  endfunction

endpackage

// File: rtl/mc_sequencer_watchdog.sv
// seq_watchdog: clear/increment counter with a terminal flag that bounds the
// number of cycles the sequencer may spend in one memory phase.
module seq_watchdog #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam logic [TO_W-1:0] CNT_MAX  = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0] CNT_TERM = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0] CNT_ONE  = TO_W'(1);

  logic [TO_W-1:0] cnt_reg;

  // Count phase cycles; saturate so a late handshake cannot wrap the count
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (inc && (cnt_reg != CNT_MAX)) begin
      cnt_reg <= cnt_reg + CNT_ONE;
    end
  end

  // The current cycle is the TIMEOUT-th (or later) cycle of the phase
  assign expired = inc && (cnt_reg >= CNT_TERM);

endmodule

// File: rtl/mc_sequencer.sv
// mc_sequencer: multi-cycle fetch/decode/memory/write-back sequencer for the
// NPC core. Optional performance counters are built when SEQ_PERF_EN is
// defined; the default build omits the perf_* ports and counters.
module mc_sequencer
  import mc_sequencer_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ifu_req_valid,
  input  logic        ifu_req_ready,
  input  logic        ifu_rsp_valid,
  input  logic [31:0] ifu_rsp_inst,
  output logic [31:0] inst_q,
  input  logic        dec_RegWr,
  input  logic        dec_MemRd,
  input  logic        dec_MemWr,
  input  logic        dec_ebreak,
  input  logic        dec_illegal,
  output logic        lsu_req_valid,
  output logic        lsu_req_we,
  input  logic        lsu_req_ready,
  input  logic        lsu_rsp_valid,
  output logic        pc_we,
  output logic        rf_we,
  output logic        retire,
  output logic        halted,
  output logic [1:0]  halt_code
`ifdef SEQ_PERF_EN
  ,
  output logic [63:0] perf_cycle,
  output logic [63:0] perf_instret
`endif
);

  seq_state_t  state_reg, state_next;
  halt_code_t  halt_code_reg, halt_code_next;
  logic [31:0] inst_q_reg;
  logic        mem_we_reg;
  logic        rf_wr_reg;
  logic        wd_clr;
  logic        wd_inc;
  logic        wd_expired;

  // State, halt reason and the per-instruction attributes captured in DECODE
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= SEQ_IDLE;
      halt_code_reg <= HALT_NONE;
      mem_we_reg    <= 1'b0;
      rf_wr_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      halt_code_reg <= halt_code_next;
      if (state_reg == SEQ_DECODE) begin
        mem_we_reg <= dec_MemWr;
        rf_wr_reg  <= dec_RegWr;
      end
    end
  end

  // Latch the instruction word only when the fetch response is accepted
  always_ff @(posedge clk) begin
    if (!rst) begin
      inst_q_reg <= '0;
    end else if ((state_reg == SEQ_IF_WAIT) && ifu_rsp_valid) begin
      inst_q_reg <= ifu_rsp_inst;
    end
  end

  // Next-state selection; handshakes and responses take precedence over the watchdog
  always_comb begin
    state_next     = state_reg;
    halt_code_next = halt_code_reg;
    unique case (state_reg)
      SEQ_IDLE: begin
        state_next = SEQ_IF_REQ;
      end
      SEQ_IF_REQ: begin
        if (ifu_req_ready) begin
          state_next = SEQ_IF_WAIT;
        end else if (wd_expired) begin
          state_next     = SEQ_HALT;
          halt_code_next = HALT_TIMEOUT;
        end
      end
      SEQ_IF_WAIT: begin
        if (ifu_rsp_valid) begin
          state_next = SEQ_DECODE;
        end else if (wd_expired) begin
          state_next     = SEQ_HALT;
          halt_code_next = HALT_TIMEOUT;
        end
      end
      SEQ_DECODE: begin
        if (dec_illegal) begin
          state_next     = SEQ_HALT;
          halt_code_next = HALT_ILLEGAL;
        end else if (dec_ebreak) begin
          state_next     = SEQ_HALT;
          halt_code_next = HALT_EBREAK;
        end else if (dec_MemRd || dec_MemWr) begin
          state_next = SEQ_MEM_REQ;
        end else begin
          state_next = SEQ_WB;
        end
      end
      SEQ_MEM_REQ: begin
        if (lsu_req_ready) begin
          state_next = SEQ_MEM_WAIT;
        end else if (wd_expired) begin
          state_next     = SEQ_HALT;
          halt_code_next = HALT_TIMEOUT;
        end
      end
      SEQ_MEM_WAIT: begin
        if (lsu_rsp_valid) begin
          state_next = SEQ_WB;
        end else if (wd_expired) begin
          state_next     = SEQ_HALT;
          halt_code_next = HALT_TIMEOUT;
        end
      end
      SEQ_WB: begin
        state_next = SEQ_IF_REQ;
      end
      SEQ_HALT: begin
        state_next = SEQ_HALT;
      end
      default: begin
        state_next = SEQ_IDLE;
      end
    endcase
  end

  // The watchdog restarts on entry to each request state and runs through its wait state
  assign wd_clr = ((state_next == SEQ_IF_REQ)  && (state_reg != SEQ_IF_REQ)) ||
                  ((state_next == SEQ_MEM_REQ) && (state_reg != SEQ_MEM_REQ));
  assign wd_inc = is_mem_phase(state_reg);

  seq_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (wd_clr),
    .inc     (wd_inc),
    .expired (wd_expired)
  );

  // Moore outputs decoded from the registered state
  assign ifu_req_valid = (state_reg == SEQ_IF_REQ);
  assign lsu_req_valid = (state_reg == SEQ_MEM_REQ);
  assign lsu_req_we    = (state_reg == SEQ_MEM_REQ) && mem_we_reg;
  assign pc_we         = (state_reg == SEQ_WB);
  assign retire        = (state_reg == SEQ_WB);
  assign rf_we         = (state_reg == SEQ_WB) && rf_wr_reg;
  assign halted        = (state_reg == SEQ_HALT);
  assign halt_code     = halt_code_reg;
  assign inst_q        = inst_q_reg;

`ifdef SEQ_PERF_EN
  logic [63:0] perf_cycle_reg;
  logic [63:0] perf_instret_reg;

  // Busy-cycle and retired-instruction counters, wrapping modulo 2^64
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_cycle_reg   <= '0;
      perf_instret_reg <= '0;
    end else begin
      if ((state_reg != SEQ_IDLE) && (state_reg != SEQ_HALT)) begin
        perf_cycle_reg <= perf_cycle_reg + 64'd1;
      end
      if (state_reg == SEQ_WB) begin
        perf_instret_reg <= perf_instret_reg + 64'd1;
      end
    end
  end

  assign perf_cycle   = perf_cycle_reg;
  assign perf_instret = perf_instret_reg;
`endif

endmodule

// File: tb/tb_mc_sequencer.sv
// Scoreboard bench for mc_sequencer: the driver acts as instruction and data
// memory, predicts each instruction's outcome from delays and class, and a
// monitor compares every retire/halt event against the predictions.
module tb_mc_sequencer;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
  logic [31:0] ifu_rsp_inst, inst_q;
  logic        dec_RegWr, dec_MemRd, dec_MemWr, dec_ebreak, dec_illegal;
  logic        lsu_req_valid, lsu_req_we, lsu_req_ready, lsu_rsp_valid;
  logic        pc_we, rf_we, retire, halted;
  logic [1:0]  halt_code;
`ifdef SEQ_PERF_EN
  logic [63:0] perf_cycle, perf_instret;
`endif

  always #5 clk = ~clk;

  mc_sequencer #(.TIMEOUT(TO), .TO_W(3)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_inst(ifu_rsp_inst),
    .inst_q(inst_q),
    .dec_RegWr(dec_RegWr), .dec_MemRd(dec_MemRd), .dec_MemWr(dec_MemWr),
    .dec_ebreak(dec_ebreak), .dec_illegal(dec_illegal),
    .lsu_req_valid(lsu_req_valid), .lsu_req_we(lsu_req_we),
    .lsu_req_ready(lsu_req_ready), .lsu_rsp_valid(lsu_rsp_valid),
    .pc_we(pc_we), .rf_we(rf_we), .retire(retire), .halted(halted),
    .halt_code(halt_code)
`ifdef SEQ_PERF_EN
    , .perf_cycle(perf_cycle)
    , .perf_instret(perf_instret)
`endif
  );

  // Toy decoder on inst_q[2:0]: 0/1 ALU (RegWr=inst[3]), 2 load, 3 store,
  // 4 ebreak, 5 illegal, 6 illegal+ebreak+load, 7 ebreak+store.
  logic [2:0] cls_q;
  assign cls_q       = inst_q[2:0];
  assign dec_illegal = (cls_q == 3'd5) || (cls_q == 3'd6);
  assign dec_ebreak  = (cls_q == 3'd4) || (cls_q == 3'd6) || (cls_q == 3'd7);
  assign dec_MemRd   = (cls_q == 3'd2) || (cls_q == 3'd6);
  assign dec_MemWr   = (cls_q == 3'd3) || (cls_q == 3'd7);
  assign dec_RegWr   = (cls_q == 3'd2) || (((cls_q == 3'd0) || (cls_q == 3'd1)) && inst_q[3]);

  typedef struct {
    bit          halt;
    logic [1:0]  code;
    logic [31:0] inst;
    bit          chk_inst;
    bit          rf_we;
    bit          store;
    int          lat;
    int          ifu_cyc;
    int          lsu_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_txn    = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endfunction

  function automatic void bound_fail(input string name);
    n_checks++;
    $display("FAIL %s actual=no_event required=event_within_bound", name);
  endfunction

  // One memory phase: at most TO cycles; a handshake on the last allowed
  // cycle still leaves the following cycle for its response.
  function automatic void phase(input int dr, input int dw, output bit ok, output int cyc, output int vcyc);
    int h, r, deadline;
    h = dr + 1;
    r = dr + dw + 2;
    vcyc = (h < TO) ? h : TO;
    if (h > TO) begin
      ok = 1'b0; cyc = TO;
    end else begin
      deadline = (TO > h + 1) ? TO : h + 1;
      if (r <= deadline) begin ok = 1'b1; cyc = r; end
      else begin ok = 1'b0; cyc = deadline; end
    end
  endfunction

  // Outcome of one instruction; lat counts cycles from the first IF_REQ
  // cycle to the retire cycle, or to the first halted cycle.
  function automatic exp_t model(input logic [31:0] inst, input int dr1, input int dw1, input int dr2, input int dw2);
    exp_t e;
    bit   ok;
    int   c, v, c2, v2, cls;
    cls = int'(inst[2:0]);
    e.halt = 0; e.code = 2'b00; e.inst = inst; e.chk_inst = 1; e.rf_we = 0;
    e.store = 0; e.lat = 0; e.ifu_cyc = 0; e.lsu_cyc = 0;
    phase(dr1, dw1, ok, c, v);
    e.ifu_cyc = v;
    if (!ok) begin
      e.halt = 1; e.code = 2'b11; e.chk_inst = 0; e.lat = c + 1;
    end else if (cls == 5 || cls == 6) begin
      e.halt = 1; e.code = 2'b10; e.lat = c + 2;
    end else if (cls == 4 || cls == 7) begin
      e.halt = 1; e.code = 2'b01; e.lat = c + 2;
    end else if (cls == 2 || cls == 3) begin
      e.store = (cls == 3);
      phase(dr2, dw2, ok, c2, v2);
      e.lsu_cyc = v2;
      e.lat = c + 1 + c2 + 1;
      if (!ok) begin e.halt = 1; e.code = 2'b11; end
      else e.rf_we = (cls == 2);
    end else begin
      e.rf_we = inst[3];
      e.lat = c + 2;
    end
    return e;
  endfunction

  // Monitor: per-cycle invariants plus scoreboard compare on retire/halt
  int      n = 0, ifu_v = 0, lsu_v = 0;
  bit      counting = 0, halted_d = 0, after_rst = 1;
  longint  busy = 0, instret = 0;
  exp_t    me;

  always @(negedge clk) begin
    if (!rst) begin
      counting = 0; n = 0; ifu_v = 0; lsu_v = 0; halted_d = 0;
      after_rst = 1; busy = 0; instret = 0;
    end else begin
      if (counting) n++;
      else if (ifu_req_valid) begin counting = 1; n = 1; end
      if (ifu_req_valid) ifu_v++;
      if (lsu_req_valid) lsu_v++;
      chk("pc_we_vs_retire", pc_we, retire);
      chk("rf_we_outside_wb", rf_we & ~retire, 1'b0);
      if (halted) chk("activity_while_halted", {ifu_req_valid, lsu_req_valid, pc_we}, 3'b000);
      if (lsu_req_valid && sb.size() > 0) chk("lsu_req_we", lsu_req_we, sb[0].store);
      if (retire || (halted && !halted_d)) begin
        if (sb.size() == 0) begin
          chk("unexpected_event", {retire, halted}, 2'b00);
        end else begin
          me = sb.pop_front();
          n_txn++;
          $display("txn %0d: inst=%08h halt=%0b code=%0d lat=%0d/%0d ifu_cyc=%0d lsu_cyc=%0d",
                   n_txn, me.inst, halted, halt_code, n, me.lat, ifu_v, lsu_v);
          chk("halted", halted, me.halt);
          if (me.halt) chk("halt_code", halt_code, me.code);
          else chk("rf_we", rf_we, me.rf_we);
          chk("latency", n, me.lat);
          chk("ifu_valid_cycles", ifu_v, me.ifu_cyc);
          chk("lsu_valid_cycles", lsu_v, me.lsu_cyc);
          if (me.chk_inst) chk("inst_q", inst_q, me.inst);
`ifdef SEQ_PERF_EN
          chk("perf_cycle", perf_cycle, busy);
          chk("perf_instret", perf_instret, instret);
`endif
        end
        counting = 0; ifu_v = 0; lsu_v = 0;
      end
      if (after_rst) after_rst = 0;
      else if (!halted) busy++;
      if (retire) instret++;
      halted_d = halted;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    ifu_req_ready = 0; ifu_rsp_valid = 0; lsu_req_ready = 0; lsu_rsp_valid = 0;
    tick();
    chk("rst_outputs", {ifu_req_valid, lsu_req_valid, lsu_req_we, pc_we, rf_we, retire, halted}, 7'd0);
    chk("rst_inst_q", inst_q, 32'd0);
    chk("rst_halt_code", halt_code, 2'b00);
    rst = 1'b1;
  endtask

  task automatic drive_fetch(input logic [31:0] inst, input int dr, input int dw);
    int k = 0;
    while (!ifu_req_valid && k < 20) begin tick(); k++; end
    if (!ifu_req_valid) begin bound_fail("wait_ifu_req"); return; end
    repeat (dr) tick();
    ifu_req_ready = 1; tick(); ifu_req_ready = 0;
    repeat (dw) begin ifu_rsp_inst = $urandom; tick(); end
    ifu_rsp_valid = 1; ifu_rsp_inst = inst; tick();
    ifu_rsp_valid = 0; ifu_rsp_inst = $urandom;
  endtask

  task automatic drive_mem(input int dr, input int dw);
    int k = 0;
    while (!lsu_req_valid && k < 20) begin tick(); k++; end
    if (!lsu_req_valid) begin bound_fail("wait_lsu_req"); return; end
    repeat (dr) tick();
    lsu_req_ready = 1; tick(); lsu_req_ready = 0;
    repeat (dw) tick();
    lsu_rsp_valid = 1; tick(); lsu_rsp_valid = 0;
  endtask

  task automatic wait_drain();
    int k = 0;
    while (sb.size() != 0 && k < 40) begin tick(); k++; end
    if (sb.size() != 0) begin bound_fail("scoreboard_drain"); sb.delete(); end
  endtask

  task automatic run_inst(input logic [31:0] inst, input int dr1, input int dw1, input int dr2, input int dw2);
    exp_t e;
    e = model(inst, dr1, dw1, dr2, dw2);
    sb.push_back(e);
    drive_fetch(inst, dr1, dw1);
    if (e.chk_inst && (inst[2:0] == 3'd2 || inst[2:0] == 3'd3)) drive_mem(dr2, dw2);
    if (e.halt) begin
      wait_drain();
      repeat (2) tick();
      do_reset();
    end
  endtask

  function automatic logic [31:0] mk(input int cls, input bit rfw);
    logic [31:0] v;
    v = $urandom;
    v[2:0] = cls[2:0];
    v[3] = rfw;
    return v;
  endfunction

  function automatic int rnd_delay();
    return ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 1)) : int'($urandom_range(2, 5));
  endfunction

  initial begin
    int r, cls;
    ifu_req_ready = 0; ifu_rsp_valid = 0; ifu_rsp_inst = 0;
    lsu_req_ready = 0; lsu_rsp_valid = 0;
    do_reset();

    run_inst(mk(1, 1), 0, 0, 0, 0);   // addi, zero wait
    run_inst(mk(2, 1), 0, 0, 2, 0);   // lw, ready delayed 2
    run_inst(mk(3, 0), 0, 0, 0, 0);   // sw
    run_inst(mk(4, 0), 0, 0, 0, 0);   // ebreak
    run_inst(mk(1, 1), 0, 10, 0, 0);  // fetch response withheld
    run_inst(mk(1, 1), 0, 2, 0, 0);   // response on the timeout cycle
    run_inst(mk(5, 0), 0, 0, 0, 0);   // illegal
    run_inst(mk(6, 1), 0, 0, 0, 0);   // illegal beats ebreak and load
    run_inst(mk(7, 0), 0, 0, 0, 0);   // ebreak beats store

    // Reset during MEM_WAIT, then a stray load response while IDLE
    wait_drain();
    drive_fetch(mk(2, 1), 0, 0);
    begin
      int k = 0;
      while (!lsu_req_valid && k < 20) begin tick(); k++; end
      if (!lsu_req_valid) bound_fail("wait_lsu_req_abort");
    end
    lsu_req_ready = 1; tick(); lsu_req_ready = 0;
    tick();
    do_reset();
    lsu_rsp_valid = 1; ifu_rsp_valid = 1; tick();
    lsu_rsp_valid = 0; ifu_rsp_valid = 0;
    run_inst(mk(1, 1), 0, 0, 0, 0);

    for (int i = 0; i < 250; i++) begin
      r = int'($urandom_range(0, 19));
      if (r < 8) cls = int'($urandom_range(0, 1));
      else if (r < 12) cls = 2;
      else if (r < 16) cls = 3;
      else cls = r - 12;
      run_inst(mk(cls, 1'($urandom_range(0, 1))), rnd_delay(), rnd_delay(), rnd_delay(), rnd_delay());
    end

    wait_drain();
    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit actual=running required=finished");
    $fatal(1, "time limit");
  end

endmodule
